// File: rtl/aes_out_serializer.sv
// aes_out_serializer
// Captures 128-bit ciphertext blocks from a fixed-latency AES core into a
// small output buffer and streams them out as four 32-bit words, MSW first.
// Launches are credit-limited so that every block in flight always has a
// guaranteed buffer slot waiting for it.

module aes_out_serializer #(
  parameter int LATENCY = 11,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_launch,
  output logic         launch_ready,
  input  logic [127:0] core_data,
  output logic [31:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         word_last,
  output logic         overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for in_flight + fill without wrapping.
  localparam int CNT_W = $clog2(LATENCY + DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [LATENCY-1:0] dly_reg, dly_next;
  logic [CNT_W-1:0]   in_flight_reg, in_flight_next;
  logic [CNT_W-1:0]   fill_reg, fill_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [1:0]         idx_reg, idx_next;
  logic               overflow_reg, overflow_next;

  // Ciphertext storage; data only, never reset.
  logic [127:0]       buf_mem [DEPTH];

  // ---------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]   credit_sum;
  logic               launch_acc;
  logic               tap;
  logic               capture;
  logic               handshake;
  logic               pop;
  logic [127:0]       head;
  logic [31:0]        head_words [4];

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit is computed from registered counts only; a pop this cycle does
  // not free a slot until the next cycle, so the buffer can never overflow.
  assign credit_sum   = in_flight_reg + fill_reg;
  assign launch_ready = (credit_sum < DEPTH_C);
  assign launch_acc   = blk_launch & launch_ready;

  // The oldest delay-line stage marks the edge at which core_data holds
  // the ciphertext of a tracked launch.
  assign tap          = dly_reg[LATENCY-1];
  assign capture      = tap;

  assign word_valid   = (fill_reg != '0);
  assign handshake    = word_valid & word_ready;
  assign pop          = handshake & (idx_reg == 2'd3);

  assign head         = buf_mem[rd_ptr_reg];

  // Split the head entry into its four words, MSW at index 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_head_words
      assign head_words[gi] = head[127-32*gi -: 32];
    end
  endgenerate

  // Invalid cycles present zero so uninitialised storage never leaks out.
  assign word_out  = word_valid ? head_words[idx_reg] : 32'h0;
  assign word_last = word_valid & (idx_reg == 2'd3);
  assign overflow  = overflow_reg;

  // Delay line shift: accepted launches enter at the head every cycle.
  generate
    if (LATENCY == 1) begin : g_dly_one
      assign dly_next = launch_acc;
    end else begin : g_dly_many
      assign dly_next = {dly_reg[LATENCY-2:0], launch_acc};
    end
  endgenerate

  // Next-state for counters, pointers, word index and sticky error.
  always_comb begin
    in_flight_next = in_flight_reg + CNT_W'(launch_acc) - CNT_W'(tap);
    fill_next      = fill_reg + CNT_W'(capture) - CNT_W'(pop);
    wr_ptr_next    = capture ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next    = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    // The 2-bit index wraps 3 -> 0 on the same handshake that pops.
    idx_next       = handshake ? idx_reg + 2'd1 : idx_reg;
    overflow_next  = overflow_reg | (blk_launch & ~launch_ready);
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_reg       <= '0;
      in_flight_reg <= '0;
      fill_reg      <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      idx_reg       <= 2'd0;
      overflow_reg  <= 1'b0;
    end else begin
      dly_reg       <= dly_next;
      in_flight_reg <= in_flight_next;
      fill_reg      <= fill_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      idx_reg       <= idx_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Buffer write at the tail when a tracked block's ciphertext arrives.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_mem[wr_ptr_reg] <= core_data;
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// tb_aes_out_serializer
// Directed bench: a behavioural fixed-latency core model feeds core_data,
// each task drives one scenario and compares outputs inline.

`timescale 1ns/1ps

module tb_aes_out_serializer;

  localparam int LATENCY = 11;
  localparam int DEPTH   = 4;

  localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK   = 128'hdeadbeef_0badf00d_5a5a5a5a_c3c3c3c3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_launch = 1'b0;
  logic         word_ready = 1'b0;
  logic         launch_ready;
  logic [127:0] core_data;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_last;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Core model: plaintext presented with blk_launch reappears as ciphertext
  // on core_data exactly LATENCY cycles later; idle slots carry junk.
  logic [127:0] launch_ct = '0;
  logic [127:0] pipe [LATENCY];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= blk_launch ? launch_ct : JUNK;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign core_data = pipe[LATENCY-1];

  aes_out_serializer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .blk_launch   (blk_launch),
    .launch_ready (launch_ready),
    .core_data    (core_data),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_last    (word_last),
    .overflow     (overflow)
  );

  // Word w of test block k: {A0/B0/C0/D0, k, 00, w+1}.
  function automatic logic [31:0] exp_word(input logic [7:0] k, input int w);
    logic [7:0] top;
    top = 8'hA0 + 8'(16 * w);
    return {top, k, 8'h00, 8'(w + 1)};
  endfunction

  function automatic logic [127:0] blk(input logic [7:0] k);
    return {exp_word(k, 0), exp_word(k, 1), exp_word(k, 2), exp_word(k, 3)};
  endfunction

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; blk_launch = 1'b0; word_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    n_cmp++; if (word_last !== 1'b0) begin n_bad++; $display("FAIL reset_word_last: got %b want 0", word_last); end
    n_cmp++; if (word_out !== 32'h0) begin n_bad++; $display("FAIL reset_word_out: got %h want 0", word_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL reset_launch_ready: got %b want 1", launch_ready); end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_single();
    int c;
    logic [31:0] exp [4];
    exp[0] = 32'h69c4e0d8; exp[1] = 32'h6a7b0430;
    exp[2] = 32'hd8cdb780; exp[3] = 32'h70b4c55a;
    @(negedge clk);
    launch_ct = AES_CT; blk_launch = 1'b1; word_ready = 1'b1;
    n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL single_launch_ready: got %b want 1", launch_ready); end
    @(negedge clk);
    blk_launch = 1'b0;
    c = 1;
    while (word_valid !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    n_cmp++; if (c != LATENCY + 1) begin n_bad++; $display("FAIL single_latency: got cycle %0d want %0d", c, LATENCY + 1); end
    for (int w = 0; w < 4; w++) begin
      n_cmp++; if (word_out !== exp[w]) begin n_bad++; $display("FAIL single_word%0d: got %h want %h", w, word_out, exp[w]); end
      n_cmp++; if (word_last !== (w == 3)) begin n_bad++; $display("FAIL single_last%0d: got %b want %b", w, word_last, (w == 3)); end
      $display("single word %0d = %h last=%b", w, word_out, word_last);
      @(negedge clk);
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %b want 0", word_valid); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_credit();
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      blk_launch = 1'b1; launch_ct = blk(8'(i));
      n_cmp++; if (launch_ready !== (i < 4)) begin n_bad++; $display("FAIL credit_ready%0d: got %b want %b", i, launch_ready, (i < 4)); end
      if (i == 4) begin
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL credit_ovf_early: got %b want 0", overflow); end
      end
      if (i == 5) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL credit_ovf_set: got %b want 1", overflow); end
      end
      $display("credit attempt %0d launch_ready=%b", i, launch_ready);
    end
    @(negedge clk);
    blk_launch = 1'b0;
    repeat (14) @(negedge clk);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL credit_full_valid: got %b want 1", word_valid); end
    n_cmp++; if (launch_ready !== 1'b0) begin n_bad++; $display("FAIL credit_full_ready: got %b want 0", launch_ready); end
    n_cmp++; if (word_out !== exp_word(8'd0, 0)) begin n_bad++; $display("FAIL credit_held_word: got %h want %h", word_out, exp_word(8'd0, 0)); end
    word_ready = 1'b1;
    for (int g = 0; g < 16; g++) begin
      n_cmp++; if (word_out !== exp_word(8'(g / 4), g % 4)) begin n_bad++; $display("FAIL credit_word%0d: got %h want %h", g, word_out, exp_word(8'(g / 4), g % 4)); end
      n_cmp++; if (word_last !== ((g % 4) == 3)) begin n_bad++; $display("FAIL credit_last%0d: got %b want %b", g, word_last, ((g % 4) == 3)); end
      $display("credit word %0d = %h last=%b", g, word_out, word_last);
      @(negedge clk);
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL credit_drained: got %b want 0", word_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL credit_ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL credit_ready_back: got %b want 1", launch_ready); end
  endtask

  // ---------------------------------------------------------------------
  // Block B's capture edge coincides with block A's 4th-word handshake.
  task automatic test_simultaneous();
    logic [7:0] k;
    int w;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      blk_launch = (c == 0 || c == 4);
      launch_ct  = (c == 0) ? blk(8'h20) : blk(8'h21);
      word_ready = 1'b1;
      if (c == 4) begin
        n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready: got %b want 1", launch_ready); end
      end
      if (c >= 12 && c <= 19) begin
        k = (c < 16) ? 8'h20 : 8'h21;
        w = (c - 12) % 4;
        n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL simul_valid_c%0d: got %b want 1", c, word_valid); end
        n_cmp++; if (word_out !== exp_word(k, w)) begin n_bad++; $display("FAIL simul_word_c%0d: got %h want %h", c, word_out, exp_word(k, w)); end
        n_cmp++; if (word_last !== (w == 3)) begin n_bad++; $display("FAIL simul_last_c%0d: got %b want %b", c, word_last, (w == 3)); end
        $display("simul cycle %0d word = %h last=%b", c, word_out, word_last);
      end else begin
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL simul_idle_c%0d: got %b want 0", c, word_valid); end
      end
    end
    blk_launch = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_backpressure();
    logic [31:0] pat;
    logic [31:0] hold_word;
    logic        hold_last;
    logic        stall_prev;
    int k, got, c;
    pat = 32'b1011_0010_1110_0101_0011_1001_0110_1101;
    k = 0; got = 0; c = 0; stall_prev = 1'b0;
    hold_word = '0; hold_last = 1'b0;
    while (got < 32 && c < 2000) begin
      @(negedge clk);
      word_ready = pat[5'(c % 32)];
      if (k < 8 && launch_ready === 1'b1) begin
        blk_launch = 1'b1; launch_ct = blk(8'(8'h40 + k)); k++;
      end else begin
        blk_launch = 1'b0;
      end
      if (stall_prev) begin
        n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL bp_stall_valid: got %b want 1", word_valid); end
        n_cmp++; if (word_out !== hold_word) begin n_bad++; $display("FAIL bp_stall_word: got %h want %h", word_out, hold_word); end
        n_cmp++; if (word_last !== hold_last) begin n_bad++; $display("FAIL bp_stall_last: got %b want %b", word_last, hold_last); end
      end
      if (word_valid === 1'b1 && word_ready) begin
        n_cmp++; if (word_out !== exp_word(8'(8'h40 + got / 4), got % 4)) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", got, word_out, exp_word(8'(8'h40 + got / 4), got % 4)); end
        n_cmp++; if (word_last !== ((got % 4) == 3)) begin n_bad++; $display("FAIL bp_last%0d: got %b want %b", got, word_last, ((got % 4) == 3)); end
        $display("bp word %0d = %h last=%b", got, word_out, word_last);
        got++;
      end
      stall_prev = (word_valid === 1'b1) && !word_ready;
      hold_word  = word_out;
      hold_last  = word_last;
      c++;
    end
    @(negedge clk);
    blk_launch = 1'b0;
    n_cmp++; if (got != 32) begin n_bad++; $display("FAIL bp_word_count: got %0d want 32", got); end
    n_cmp++; if (k != 8) begin n_bad++; $display("FAIL bp_launch_count: got %0d want 8", k); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", word_valid); end
  endtask

  // ---------------------------------------------------------------------
  // One block buffered and two in flight when rst_n pulses low.
  task automatic test_reset_midflight();
    word_ready = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      blk_launch = (c == 0 || c == 3 || c == 4);
      launch_ct  = blk(8'(8'h60 + c));
    end
    blk_launch = 1'b0;
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL rstm_buffered: got %b want 1", word_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rstm_ovf_before: got %b want 1", overflow); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rstm_in_valid: got %b want 0", word_valid); end
    n_cmp++; if (word_out !== 32'h0) begin n_bad++; $display("FAIL rstm_in_word: got %h want 0", word_out); end
    n_cmp++; if (word_last !== 1'b0) begin n_bad++; $display("FAIL rstm_in_last: got %b want 0", word_last); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstm_in_ovf: got %b want 0", overflow); end
    n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL rstm_in_ready: got %b want 1", launch_ready); end
    $display("reset pulse applied mid-flight");
    @(negedge clk);
    rst_n = 1'b1;
    word_ready = 1'b1;
    for (int c = 13; c <= 40; c++) begin
      n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rstm_after_valid_c%0d: got %b want 0", c, word_valid); end
      if (c == 13 || c == 40) begin
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstm_after_ovf_c%0d: got %b want 0", c, overflow); end
        n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL rstm_after_ready_c%0d: got %b want 1", c, launch_ready); end
      end
      @(negedge clk);
    end
    blk_launch = 1'b1; launch_ct = blk(8'h70);
    @(negedge clk);
    blk_launch = 1'b0;
    repeat (LATENCY) @(negedge clk);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL rstm_relaunch_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== exp_word(8'h70, 0)) begin n_bad++; $display("FAIL rstm_relaunch_word: got %h want %h", word_out, exp_word(8'h70, 0)); end
    $display("relaunch word = %h", word_out);
    repeat (4) @(negedge clk);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rstm_relaunch_drained: got %b want 0", word_valid); end
  endtask

  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_credit();
    test_simultaneous();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a scenario never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
